// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler with a fixed-latency busy window.
// Optional MD_SCHED_DIV0_FAST_EN: divide by zero finishes after one busy cycle.
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] ra, rb, ma, mb, dv, uq, ur, q, r;
  logic rsg, last, an, bn;
  logic [63:0] prod;
  assign busy = state != IDLE;
  assign stall = d_is_md & (busy | start);
`ifdef MD_SCHED_DIV0_FAST_EN
  assign last = busy & ((cnt == 4'd1) | ((state == DIV) & (rb == '0)));
`else
  assign last = busy & (cnt == 4'd1);
`endif
  // sign-extending both operands makes one 64-bit product serve mult and multu
  assign prod = {{32{rsg & ra[31]}}, ra} * {{32{rsg & rb[31]}}, rb};
  assign an = rsg & ra[31];
  assign bn = rsg & rb[31];
  assign ma = an ? -ra : ra;
  assign mb = bn ? -rb : rb;
  assign dv = (mb == '0) ? 32'd1 : mb;
  assign uq = ma / dv;
  assign ur = ma % dv;
  assign q = (an ^ bn) ? -uq : uq;
  assign r = an ? -ur : ur;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? (op[1] ? DIV : MUL) : IDLE;
    else if (last) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ra <= '0;
      rb <= '0;
      rsg <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= last;
      if (!busy) begin
        if (start) begin
          ra <= a;
          rb <= b;
          rsg <= ~op[0];
          cnt <= op[1] ? 4'(DIV_LAT) : 4'(MULT_LAT);
        end else begin
          if (mthi) hi <= a;
          if (mtlo) lo <= a;
        end
      end else begin
        cnt <= last ? 4'd0 : cnt - 4'd1;
        if (last && state == MUL) {hi, lo} <= prod;
        else if (last && rb != '0) begin
          hi <= r;
          lo <= q;
        end
      end
    end
  end
endmodule
